// File: rtl/tile_framebuffer.sv
// Color tile buffer: pipeline read/write port plus clear (fill) and commit
// (AXI-Stream readout through a 2-entry output FIFO) command engines.
module tile_framebuffer #(
    parameter int unsigned FRAMEBUFFER_INDEX_WIDTH = 14,
    parameter int unsigned PIXEL_WIDTH             = 32
) (
    input  logic                               aclk,
    input  logic                               resetn,
    input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] colorIndexRead,
    output logic [PIXEL_WIDTH-1:0]             colorIn,
    input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] colorIndexWrite,
    input  logic                               colorWriteEnable,
    input  logic [PIXEL_WIDTH-1:0]             colorOut,
    input  logic                               cmdClear,
    input  logic                               cmdCommit,
    input  logic [FRAMEBUFFER_INDEX_WIDTH:0]   cmdSize,
    input  logic [PIXEL_WIDTH-1:0]             clearColor,
    output logic                               busy,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic                               m_axis_tlast,
    output logic [PIXEL_WIDTH-1:0]             m_axis_tdata
);

    localparam int unsigned IW    = FRAMEBUFFER_INDEX_WIDTH;
    localparam int unsigned PW    = PIXEL_WIDTH;
    localparam int unsigned SW    = FRAMEBUFFER_INDEX_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << FRAMEBUFFER_INDEX_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN
    } state_t;

    state_t state, state_next;

    logic [PW-1:0] mem [DEPTH];

    logic [IW-1:0] cnt;
    logic [IW-1:0] last_idx;
    logic [PW-1:0] fill;

    // Second FIFO slot; the first slot is the m_axis_* register set itself.
    logic [PW-1:0] sk_data;
    logic          sk_last;
    logic          sk_valid;

    logic [SW-1:0] cmd_len;
    logic          start_clear;
    logic          start_commit;
    logic          issue;
    logic          at_last;
    logic          pop;
    logic          fifo_full;
    logic [PW-1:0] rd_word;
    logic          mem_we;
    logic [IW-1:0] mem_waddr;
    logic [PW-1:0] mem_wdata;

    // Command length clamped to the tile size
    always_comb begin
        cmd_len   = (cmdSize > SW'(DEPTH)) ? SW'(DEPTH) : cmdSize;
        at_last   = (cnt == last_idx);
        pop       = m_axis_tvalid && m_axis_tready;
        fifo_full = m_axis_tvalid && sk_valid;
        rd_word   = mem[cnt];
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next   = state;
        start_clear  = 1'b0;
        start_commit = 1'b0;
        issue        = 1'b0;
        case (state)
            IDLE: begin
                // Clear takes priority; a zero length makes either command a no-op
                if (cmdClear && (cmd_len != '0)) begin
                    start_clear = 1'b1;
                    state_next  = CLEAR;
                end else if (cmdCommit && (cmd_len != '0)) begin
                    start_commit = 1'b1;
                    state_next   = STREAM;
                end
            end
            CLEAR: begin
                if (at_last) state_next = IDLE;
            end
            STREAM: begin
                // Reads land directly in the FIFO, so occupancy alone gates issue
                issue = !fifo_full;
                if (issue && at_last) state_next = DRAIN;
            end
            DRAIN: begin
                if (!sk_valid && (pop || !m_axis_tvalid)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = colorIndexWrite;
        mem_wdata = colorOut;
        if (state == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = cnt;
            mem_wdata = fill;
        end else if (state == IDLE) begin
            mem_we = colorWriteEnable;
        end
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= '0;
            last_idx <= '0;
            fill     <= '0;
        end else if (start_clear || start_commit) begin
            cnt      <= '0;
            last_idx <= IW'(cmd_len - SW'(1));
            if (start_clear) fill <= clearColor;
        end else if ((state == CLEAR) || issue) begin
            cnt <= cnt + IW'(1);
        end
    end

    // Tile storage is intentionally not reset
    always_ff @(posedge aclk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) colorIn <= '0;
        else         colorIn <= mem[colorIndexRead];
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            sk_valid      <= 1'b0;
            sk_last       <= 1'b0;
            sk_data       <= '0;
        end else if (!m_axis_tvalid || pop) begin
            if (sk_valid) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= sk_data;
                m_axis_tlast  <= sk_last;
                sk_valid      <= issue;
                if (issue) begin
                    sk_data <= rd_word;
                    sk_last <= at_last;
                end
            end else begin
                m_axis_tvalid <= issue;
                if (issue) begin
                    m_axis_tdata <= rd_word;
                    m_axis_tlast <= at_last;
                end
            end
        end else if (issue) begin
            sk_valid <= 1'b1;
            sk_data  <= rd_word;
            sk_last  <= at_last;
        end
    end

endmodule

// File: tb/tb_tile_framebuffer.sv
// Self-checking bench for tile_framebuffer: directed command sequences with
// randomized data/backpressure checked against an array model of the tile.
module tb_tile_framebuffer;

    localparam int unsigned IW    = 6;
    localparam int unsigned PW    = 32;
    localparam int unsigned DEPTH = 1 << IW;

    logic          aclk = 1'b0;
    logic          resetn;
    logic [IW-1:0] colorIndexRead;
    logic [PW-1:0] colorIn;
    logic [IW-1:0] colorIndexWrite;
    logic          colorWriteEnable;
    logic [PW-1:0] colorOut;
    logic          cmdClear;
    logic          cmdCommit;
    logic [IW:0]   cmdSize;
    logic [PW-1:0] clearColor;
    logic          busy;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [PW-1:0] m_axis_tdata;

    logic [PW-1:0] mem_m [DEPTH];
    int n_cmp = 0;
    int n_bad = 0;

    tile_framebuffer #(
        .FRAMEBUFFER_INDEX_WIDTH(IW),
        .PIXEL_WIDTH(PW)
    ) dut (
        .aclk(aclk),
        .resetn(resetn),
        .colorIndexRead(colorIndexRead),
        .colorIn(colorIn),
        .colorIndexWrite(colorIndexWrite),
        .colorWriteEnable(colorWriteEnable),
        .colorOut(colorOut),
        .cmdClear(cmdClear),
        .cmdCommit(cmdCommit),
        .cmdSize(cmdSize),
        .clearColor(clearColor),
        .busy(busy),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tdata(m_axis_tdata)
    );

    always #5 aclk = ~aclk;

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int idx, input logic [PW-1:0] val);
        logic was_busy;
        was_busy         = busy;
        colorIndexWrite  = IW'(idx);
        colorOut         = val;
        colorWriteEnable = 1'b1;
        tick;
        colorWriteEnable = 1'b0;
        if (!was_busy) mem_m[idx] = val;
    endtask

    task automatic rd_check(input string tag, input int idx);
        colorIndexRead = IW'(idx);
        tick;
        check(tag, 64'(colorIn), 64'(mem_m[idx]));
    endtask

    // Clear of n pixels; optionally fires a commit in the same cycle.
    task automatic do_clear(input int n, input logic [PW-1:0] color, input bit with_commit);
        int  len;
        int  busy_cycles;
        bit  seen_valid;
        len = (n > int'(DEPTH)) ? int'(DEPTH) : n;
        cmdClear   = 1'b1;
        cmdCommit  = with_commit;
        cmdSize    = (IW+1)'(n);
        clearColor = color;
        m_axis_tready = 1'b1;
        tick;
        cmdClear  = 1'b0;
        cmdCommit = 1'b0;
        busy_cycles = 0;
        seen_valid  = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (!busy) break;
            busy_cycles++;
            if (m_axis_tvalid) seen_valid = 1'b1;
            // Pipeline write to an index outside small clears; must be dropped
            colorIndexWrite  = IW'(40);
            colorOut         = 32'hBAD0_BAD0;
            colorWriteEnable = (c == 0);
            tick;
            colorWriteEnable = 1'b0;
        end
        for (int c = 0; c < 4; c++) begin
            if (m_axis_tvalid || busy) seen_valid = 1'b1;
            tick;
        end
        check("clear_busy_cycles", 64'(busy_cycles), 64'(len));
        check("clear_no_stream", 64'(seen_valid), 64'(0));
        for (int i = 0; i < len; i++) mem_m[i] = color;
    endtask

    task automatic do_commit(input int n, input int pct, input bit chk_timing);
        int   len;
        int   got;
        int   cyc;
        logic prev_stall;
        logic [PW-1:0] prev_d;
        logic prev_l;
        len = (n > int'(DEPTH)) ? int'(DEPTH) : n;
        cmdCommit = 1'b1;
        cmdSize   = (IW+1)'(n);
        m_axis_tready = 1'b0;
        tick;
        cmdCommit = 1'b0;
        check("commit_busy_c1", 64'(busy), 64'(1));
        if (chk_timing) check("commit_tvalid_c1", 64'(m_axis_tvalid), 64'(0));
        got = 0;
        cyc = 1;
        prev_stall = 1'b0;
        prev_d = '0;
        prev_l = 1'b0;
        while (got < len && cyc < 600) begin
            if (prev_stall) begin
                check("stall_tvalid", 64'(m_axis_tvalid), 64'(1));
                check("stall_tdata", 64'(m_axis_tdata), 64'(prev_d));
                check("stall_tlast", 64'(m_axis_tlast), 64'(prev_l));
            end
            m_axis_tready = ($urandom_range(99) < 32'(pct));
            if (m_axis_tvalid && m_axis_tready) begin
                check("beat_data", 64'(m_axis_tdata), 64'(mem_m[got]));
                check("beat_last", 64'(m_axis_tlast), 64'(got == len - 1));
                if (chk_timing) check("beat_cycle", 64'(cyc), 64'(got + 2));
                got++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_d     = m_axis_tdata;
            prev_l     = m_axis_tlast;
            tick;
            cyc++;
        end
        m_axis_tready = 1'b0;
        check("commit_beats", 64'(got), 64'(len));
        if (chk_timing) check("commit_end_cycle", 64'(cyc), 64'(len + 2));
        check("commit_busy_end", 64'(busy), 64'(0));
        check("commit_tvalid_end", 64'(m_axis_tvalid), 64'(0));
    endtask

    initial begin
        int   got;
        logic ok;
        logic [PW-1:0] v;
        int   ra;
        int   wa;
        logic we;
        logic [PW-1:0] exp_rd;

        resetn = 1'b0;
        colorWriteEnable = 1'b0;
        cmdClear = 1'b0;
        cmdCommit = 1'b0;
        m_axis_tready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            colorIndexRead  = IW'($urandom);
            colorIndexWrite = IW'($urandom);
            colorOut        = $urandom;
            cmdSize         = (IW+1)'($urandom);
            clearColor      = $urandom;
            m_axis_tready   = 1'($urandom);
            tick;
        end
        check("rst_colorIn", 64'(colorIn), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        check("rst_tlast", 64'(m_axis_tlast), 64'(0));
        check("rst_tdata", 64'(m_axis_tdata), 64'(0));
        m_axis_tready = 1'b0;
        resetn = 1'b1;
        tick;

        for (int i = 0; i < int'(DEPTH); i++) wr(i, $urandom);
        wr(5, 32'hDEAD_BEEF);
        rd_check("rd_after_wr_5", 5);

        // Random pipeline traffic, including same-address read/write
        for (int c = 0; c < 40; c++) begin
            ra = int'($urandom_range(DEPTH - 1));
            wa = ($urandom_range(3) == 0) ? ra : int'($urandom_range(DEPTH - 1));
            we = 1'($urandom);
            v  = $urandom;
            colorIndexRead   = IW'(ra);
            colorIndexWrite  = IW'(wa);
            colorOut         = v;
            colorWriteEnable = we;
            exp_rd = mem_m[ra];
            tick;
            colorWriteEnable = 1'b0;
            check("rand_rd", 64'(colorIn), 64'(exp_rd));
            if (we) mem_m[wa] = v;
        end

        do_clear(4, 32'h1122_3344, 1'b0);
        for (int i = 0; i <= 4; i++) rd_check("clear_rd", i);
        rd_check("clear_dropped_wr", 40);

        for (int i = 0; i < int'(DEPTH); i++) wr(i, 32'(i));
        do_commit(8, 100, 1'b1);
        do_commit(16, 50, 1'b0);

        do_clear(2, 32'hA5A5_0001, 1'b1);
        rd_check("both_cmd_rd0", 0);
        rd_check("both_cmd_rd2", 2);
        do_clear(0, 32'hFFFF_FFFF, 1'b0);
        rd_check("zero_clear_rd", 0);

        cmdCommit = 1'b1;
        cmdSize   = '0;
        m_axis_tready = 1'b1;
        tick;
        cmdCommit = 1'b0;
        ok = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (busy || m_axis_tvalid) ok = 1'b0;
            tick;
        end
        check("zero_commit_idle", 64'(ok), 64'(1));

        for (int i = 0; i < int'(DEPTH); i++) wr(i, $urandom);
        do_commit(64, 60, 1'b0);
        do_commit(100, 70, 1'b0);
        do_clear(100, 32'h0BAD_F00D, 1'b0);
        rd_check("clamp_clear_rd63", 63);
        for (int i = 0; i < int'(DEPTH); i++) wr(i, 32'(i));

        // Reset in the middle of a stream
        cmdCommit = 1'b1;
        cmdSize   = (IW+1)'(8);
        m_axis_tready = 1'b1;
        tick;
        cmdCommit = 1'b0;
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            if (m_axis_tvalid) begin
                check("mid_beat", 64'(m_axis_tdata), 64'(got));
                got++;
            end
            tick;
        end
        check("mid_beats_before_rst", 64'(got), 64'(3));
        resetn = 1'b0;
        #1;
        check("mid_rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        tick;
        tick;
        resetn = 1'b1;
        ok = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick;
            if (busy || m_axis_tvalid) ok = 1'b0;
        end
        check("post_rst_quiet", 64'(ok), 64'(1));
        m_axis_tready = 1'b0;
        for (int i = 0; i < 8; i++) rd_check("post_rst_mem", i);
        do_commit(8, 100, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
